key_encoder: RTL and testbench

- Front-end stage of the piano. Synchronises and debounces seven note buttons and two octave buttons.
- Resolves the pressed notes to a single 3-bit note code and keeps a saturating 3-bit octave register.
- Drives the note/octave inputs of the tone-generation stage directly.
- Note code 0 means silence; the downstream tone stage treats code 0 as "no note".

---
 rtl/piano_pkg.sv | 36 +++
 rtl/debouncer.sv | 38 +++
 rtl/key_encoder.sv | 135 +++++++++++++
 tb/tb_key_encoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared note/octave definitions for the piano front end and tone stage.
package piano_pkg;

  localparam int NOTE_W   = 3;
  localparam int OCT_W    = 3;
  localparam int NUM_KEYS = 7;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_NONE = 3'd0,
    NOTE_C    = 3'd1,
    NOTE_D    = 3'd2,
    NOTE_E    = 3'd3,
    NOTE_F    = 3'd4,
    NOTE_G    = 3'd5,
    NOTE_A    = 3'd6,
    NOTE_B    = 3'd7
  } note_e;

  localparam logic [OCT_W-1:0] OCT_MAX = 3'd7;

  typedef enum logic {
    SUS_PLAY = 1'b0,
    SUS_HOLD = 1'b1
  } sus_state_e;

  // Lowest pressed key wins, so C beats every other note.
  function automatic logic [NOTE_W-1:0] note_priority(input logic [NUM_KEYS-1:0] keys);
    logic [NOTE_W-1:0] code;
    code = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) code = NOTE_W'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_100M,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      dout    <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // Any sample agreeing with the stable state restarts the interval.
      if (sync_p1 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        dout <= ~dout;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_encoder.sv
// Piano key front end: debounces note/octave buttons, encodes the note, tracks octave.
// Optional release sustain is enabled by defining KEY_SUSTAIN_EN.
module key_encoder
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int OCT_RESET       = 3,
  parameter int SUSTAIN_CYCLES  = 25000000
) (
  input  logic                clk_100M,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] btn_note,
  input  logic                btn_oct_up,
  input  logic                btn_oct_dn,
  output logic [NOTE_W-1:0]   note,
  output logic [OCT_W-1:0]    octave,
  output logic                key_valid
);

  if (DEBOUNCE_CYCLES < 2 || OCT_RESET < 0 || OCT_RESET > 7 || SUSTAIN_CYCLES < 1) begin : g_bad_param
    $error("key_encoder: parameter out of range");
  end

  logic [NUM_KEYS-1:0] note_db;
  logic                up_db;
  logic                dn_db;
  logic                up_prev;
  logic                dn_prev;
  logic [NOTE_W-1:0]   resolved;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_note_db
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_100M (clk_100M),
      .rst      (rst),
      .din      (btn_note[i]),
      .dout     (note_db[i])
    );
  end

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_100M (clk_100M),
    .rst      (rst),
    .din      (btn_oct_up),
    .dout     (up_db)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk_100M (clk_100M),
    .rst      (rst),
    .din      (btn_oct_dn),
    .dout     (dn_db)
  );

  assign resolved = note_priority(note_db);

  function automatic logic [OCT_W-1:0] step_octave(
    input logic [OCT_W-1:0] oct,
    input logic             up,
    input logic             dn
  );
    if (up && !dn && oct != OCT_MAX) return oct + 1'b1;
    if (dn && !up && oct != '0)      return oct - 1'b1;
    return oct;
  endfunction

  // Debounced -> octave register; edge detect gives one step per press.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      up_prev <= 1'b0;
      dn_prev <= 1'b0;
      octave  <= OCT_W'(OCT_RESET);
    end else begin
      up_prev <= up_db;
      dn_prev <= dn_db;
      octave  <= step_octave(octave, up_db & ~up_prev, dn_db & ~dn_prev);
    end
  end

`ifdef KEY_SUSTAIN_EN
  localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);

  sus_state_e       state;
  logic [SUS_W-1:0] sus_cnt;

  // Debounced -> note register, with the last note held after release.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state     <= SUS_PLAY;
      sus_cnt   <= '0;
      note      <= NOTE_NONE;
      key_valid <= 1'b0;
    end else begin
      case (state)
        SUS_PLAY: begin
          if (resolved != NOTE_NONE) begin
            note      <= resolved;
            key_valid <= 1'b1;
          end else if (note != NOTE_NONE) begin
            state   <= SUS_HOLD;
            sus_cnt <= SUS_W'(SUSTAIN_CYCLES - 1);
          end else begin
            key_valid <= 1'b0;
          end
        end
        SUS_HOLD: begin
          if (resolved != NOTE_NONE) begin
            note      <= resolved;
            key_valid <= 1'b1;
            state     <= SUS_PLAY;
          end else if (sus_cnt == '0) begin
            note      <= NOTE_NONE;
            key_valid <= 1'b0;
            state     <= SUS_PLAY;
          end else begin
            sus_cnt <= sus_cnt - 1'b1;
          end
        end
        default: state <= SUS_PLAY;
      endcase
    end
  end
`else
  // Debounced -> note register.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      note      <= NOTE_NONE;
      key_valid <= 1'b0;
    end else begin
      note      <= resolved;
      key_valid <= (resolved != NOTE_NONE);
    end
  end
`endif

endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder with a cycle-level behavioural reference model.
module tb_key_encoder;

  localparam int DB   = 4;
  localparam int SUS  = 8;
  localparam int OCTR = 3;

  logic       clk_100M = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] btn_note = '0;
  logic       btn_oct_up = 1'b0;
  logic       btn_oct_dn = 1'b0;
  logic [2:0] note;
  logic [2:0] octave;
  logic       key_valid;

  always #5 clk_100M = ~clk_100M;

  key_encoder #(
    .DEBOUNCE_CYCLES (DB),
    .OCT_RESET       (OCTR),
    .SUSTAIN_CYCLES  (SUS)
  ) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .btn_note   (btn_note),
    .btn_oct_up (btn_oct_up),
    .btn_oct_dn (btn_oct_dn),
    .note       (note),
    .octave     (octave),
    .key_valid  (key_valid)
  );

  typedef struct packed {
    logic [2:0] note;
    logic [2:0] oct;
    logic       vld;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: raw input history, debounced levels, outputs.
  logic [8:0] hist[$];
  logic [8:0] m_db;
  logic [8:0] m_db_prev;
  int         m_note;
  int         m_oct;
  int         m_z;

  function automatic int lowest_key(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(9'd0);
    m_db      = '0;
    m_db_prev = '0;
    m_note    = 0;
    m_oct     = OCTR;
    m_z       = 0;
  endfunction

  function automatic void model_edge(input logic [8:0] raw);
    int         r;
    logic       up_p;
    logic       dn_p;
    logic       flip;
    logic [8:0] nd;
    r = lowest_key(m_db[6:0]);
`ifdef KEY_SUSTAIN_EN
    if (r != 0) begin
      m_note = r;
      m_z    = 0;
    end else if (m_note != 0) begin
      m_z++;
      if (m_z > SUS) m_note = 0;
    end
`else
    m_note = r;
`endif
    up_p = m_db[7] & ~m_db_prev[7];
    dn_p = m_db[8] & ~m_db_prev[8];
    if (up_p && !dn_p && m_oct < 7) m_oct++;
    else if (dn_p && !up_p && m_oct > 0) m_oct--;
    // A level changes once the last DB synchronised samples all disagree with it.
    hist.push_front(raw);
    void'(hist.pop_back());
    nd = m_db;
    for (int b = 0; b < 9; b++) begin
      flip = 1'b1;
      for (int i = 2; i < DB + 2; i++) if (hist[i][b] == m_db[b]) flip = 1'b0;
      if (flip) nd[b] = ~m_db[b];
    end
    m_db_prev = m_db;
    m_db      = nd;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.note = 3'(m_note);
    e.oct  = 3'(m_oct);
    e.vld  = (m_note != 0);
    return e;
  endfunction

  task automatic cycle(input logic [6:0] n, input logic u, input logic d);
    btn_note   = n;
    btn_oct_up = u;
    btn_oct_dn = d;
    @(posedge clk_100M);
    if (rst) model_reset();
    else model_edge({d, u, n});
    sb.push_back(model_out());
    #1;
  endtask

  task automatic hold(input logic [6:0] n, input logic u, input logic d, input int cycles);
    for (int i = 0; i < cycles; i++) cycle(n, u, d);
  endtask

  task automatic check_now(input string name, input exp_t e);
    checks++;
    if (note === e.note && octave === e.oct && key_valid === e.vld) passes++;
    else $display("FAIL %s t=%0t got note=%0d oct=%0d vld=%0b want note=%0d oct=%0d vld=%0b",
                  name, $time, note, octave, key_valid, e.note, e.oct, e.vld);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input logic [6:0] n, input logic u, input logic d);
    rst = 1'b1;
    #1;
    sb.delete();
    model_reset();
    check_now("async_reset", model_out());
    hold(n, u, d, 3);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_100M);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_now("scoreboard", e);
      end
    end
  end

  initial begin : stimulus
    logic [6:0] n;
    model_reset();
    hold(7'd0, 1'b0, 1'b0, 3);
    rst = 1'b0;
    hold(7'd0, 1'b0, 1'b0, 4);

    hold(7'b0000100, 1'b0, 1'b0, 20);
    hold(7'b0000000, 1'b0, 1'b0, 20 + SUS);

    hold(7'b1010010, 1'b0, 1'b0, 20);
    hold(7'b1010000, 1'b0, 1'b0, 20);
    hold(7'b0000000, 1'b0, 1'b0, 20 + SUS);

    hold(7'b0000001, 1'b0, 1'b0, 3);
    hold(7'b0000000, 1'b0, 1'b0, 15);

    for (int i = 0; i < 6; i++) begin
      hold(7'd0, 1'b1, 1'b0, 8);
      hold(7'd0, 1'b0, 1'b0, 8);
    end
    for (int i = 0; i < 9; i++) begin
      hold(7'd0, 1'b0, 1'b1, 8);
      hold(7'd0, 1'b0, 1'b0, 8);
    end
    hold(7'd0, 1'b1, 1'b0, 100);
    hold(7'd0, 1'b0, 1'b0, 10);

    hold(7'd0, 1'b1, 1'b1, 12);
    hold(7'd0, 1'b1, 1'b0, 12);
    hold(7'd0, 1'b0, 1'b0, 12);

    hold(7'b0001000, 1'b1, 1'b0, 12);
    async_reset(7'b0001000, 1'b1, 1'b0);
    hold(7'b0001000, 1'b1, 1'b0, 12);
    hold(7'd0, 1'b0, 1'b0, 12 + SUS);

    for (int blk = 0; blk < 400; blk++) begin
      n = 7'($urandom);
      if ($urandom_range(0, 2) == 0) n = '0;
      hold(n, 1'($urandom), 1'($urandom), $urandom_range(1, 8));
      if ($urandom_range(0, 99) == 0) async_reset(n, 1'b0, 1'b0);
    end
    hold(7'd0, 1'b0, 1'b0, 20 + SUS);

    @(negedge clk_100M);
    @(negedge clk_100M);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
